// File: rtl/aud_pkg.sv
// Shared types and default sizes for the codec recorder.
package aud_pkg;

  localparam int AUD_DATA_W = 16;
  localparam int AUD_ADDR_W = 20;
  localparam int AUD_CNT_W  = $clog2(AUD_DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_PAUSE = 3'd4
  } rec_state_t;

endpackage

// File: rtl/aud_sync_edge.sv
// Two-flop synchronizer for an asynchronous codec line, with registered
// single-cycle rise/fall pulses (3 clk latency from pin to pulse).
module aud_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic meta;
  logic prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta   <= 1'b0;
      o_q    <= 1'b0;
      prev   <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      meta   <= i_d;
      o_q    <= meta;
      prev   <= o_q;
      o_rise <= o_q & ~prev;
      o_fall <= ~o_q & prev;
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// Receive side of the WM8731 I2S link: one SRAM write per captured ADC word.
// Define AUD_REC_STEREO_EN to also capture the right channel at odd addresses.
module aud_recorder
  import aud_pkg::*;
#(
  parameter int          ADDR_W   = AUD_ADDR_W,
  parameter int          DATA_W   = AUD_DATA_W,
  parameter int unsigned MAX_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_bclk,
  input  logic              i_lrc,
  input  logic              i_adcdat,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W:0]   o_length,
  output logic              o_busy,
  output logic              o_full,
  output rec_state_t        o_state
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

  rec_state_t        state, state_n;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len;
  logic              full, wr, busy;

  logic bclk_rise, bclk_level_unused, bclk_fall_unused;
  logic lrc_rise, lrc_fall, lrc_level_unused;
  logic dat_q, dat_rise_unused, dat_fall_unused;
  logic frame_edge;

  aud_sync_edge u_bclk_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_bclk),
    .o_q(bclk_level_unused), .o_rise(bclk_rise), .o_fall(bclk_fall_unused)
  );

  aud_sync_edge u_lrc_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_lrc),
    .o_q(lrc_level_unused), .o_rise(lrc_rise), .o_fall(lrc_fall)
  );

  // Same two stages as BCLK so a bit is read while BCLK is still high.
  aud_sync_edge u_dat_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_adcdat),
    .o_q(dat_q), .o_rise(dat_rise_unused), .o_fall(dat_fall_unused)
  );

`ifdef AUD_REC_STEREO_EN
  logic chan;  // 0: next word is left (LRCK fall), 1: right (LRCK rise)

  assign frame_edge = chan ? lrc_rise : lrc_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chan <= 1'b0;
    end else if (state == S_IDLE) begin
      chan <= 1'b0;
    end else if (state == S_STORE) begin
      chan <= ~chan;
    end
  end
`else
  logic unused_lrc_rise;

  assign unused_lrc_rise = lrc_rise;
  assign frame_edge      = lrc_fall;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // stop beats pause beats start; ALIGN guarantees only whole frames are shifted.
  always_comb begin
    state_n = state;
    if (state == S_IDLE) begin
      if (i_start) state_n = S_ALIGN;
    end else if (i_stop) begin
      state_n = S_IDLE;
    end else if (i_pause && state != S_PAUSE) begin
      state_n = S_PAUSE;
    end else begin
      case (state)
        S_ALIGN: if (frame_edge) state_n = S_SHIFT;
        S_SHIFT: if (bclk_rise && bit_cnt == LAST_BIT) state_n = S_STORE;
        S_STORE: state_n = (addr == LAST_ADDR) ? S_IDLE : S_ALIGN;
        S_PAUSE: if (i_start) state_n = S_ALIGN;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // bit_cnt 0 is the I2S delay slot; counts 1..DATA_W shift MSB..LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state != S_SHIFT) begin
      bit_cnt <= '0;
    end else if (bclk_rise) begin
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_cnt != '0) shreg <= {shreg[DATA_W-2:0], dat_q};
    end
  end

  // A write already on the bus in S_STORE always commits, even under pause/stop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr <= '0;
      len  <= '0;
      full <= 1'b0;
      wr   <= 1'b0;
      busy <= 1'b0;
    end else begin
      wr   <= (state_n == S_STORE);
      busy <= (state != S_IDLE);
      if (state == S_IDLE && i_start) begin
        addr <= '0;
        len  <= '0;
        full <= 1'b0;
      end else if (state == S_STORE) begin
        addr <= addr + 1'b1;
        len  <= len + 1'b1;
        if (addr == LAST_ADDR) full <= 1'b1;
      end
    end
  end

  // o_wr is a bare one-cycle strobe with no back-pressure: the SRAM takes the
  // write in that cycle, and o_address/o_data are meaningful only while it is high.
  assign o_wr      = wr;
  assign o_address = addr;
  assign o_data    = shreg;
  assign o_length  = len;
  assign o_busy    = busy;
  assign o_full    = full;
  assign o_state   = state;

endmodule
